// File: rtl/pkg_integralImageCache.sv
// Shared types for the integral-image cache: scheduler states, tile sizing, tile origin.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package pkg_integralImageCache;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    FILL    = 3'd1,
    SCAN    = 3'd2,
    ADVANCE = 3'd3,
    DONE    = 3'd4
  } sched_state_t;

  localparam int DEF_TILE_W = 24;
  localparam int DEF_TILE_H = 24;
  localparam int ORIGIN_W   = 10;

  // Words held by the cache for one tile.
  function automatic int tile_words(input int w, input int h);
    return w * h;
  endfunction

  localparam int TILE_WORDS = DEF_TILE_W * DEF_TILE_H;

  // Tile origin in pixels, consumed by the detector.
  typedef struct packed {
    logic [ORIGIN_W-1:0] x;
    logic [ORIGIN_W-1:0] y;
  } tile_origin_t;

endpackage

// File: rtl/integral_cache_fill_scheduler_if.sv
// Handshake and status bundle between the fill scheduler and its neighbours.
// Latency: n/a (wires only).
// Backpressure: carries the upstream/loader valid-wanted pairs unchanged.
interface integral_cache_fill_scheduler_if #(
  parameter int COORD_W = 10
);
  logic               frame_start;
  logic               up_data_ready;
  logic               up_data_wanted;
  logic               ld_data_ready;
  logic               ld_data_wanted;
  logic               fill_start;
  logic               scan_start;
  logic               scan_done;
  logic [COORD_W-1:0] tile_x;
  logic [COORD_W-1:0] tile_y;
  logic               busy;
  logic               frame_done;

  modport master (
    input  frame_start, up_data_ready, ld_data_wanted, scan_done,
    output up_data_wanted, ld_data_ready, fill_start, scan_start,
           tile_x, tile_y, busy, frame_done
  );

  modport slave (
    output frame_start, up_data_ready, ld_data_wanted, scan_done,
    input  up_data_wanted, ld_data_ready, fill_start, scan_start,
           tile_x, tile_y, busy, frame_done
  );
endinterface

// File: rtl/tile_origin_counter.sv
// Tile index and pixel-origin counters walking the frame in raster order.
// Latency: origin updates on the edge after clear/advance.
// Backpressure: none; advances only when told to.
module tile_origin_counter #(
  parameter int TILES_X = 38,
  parameter int TILES_Y = 28,
  parameter int STRIDE  = 8,
  parameter int COORD_W = 10
) (
  input  logic               clk,
  input  logic               resetn,
  input  logic               clear,
  input  logic               advance,
  output logic [COORD_W-1:0] tile_x,
  output logic [COORD_W-1:0] tile_y,
  output logic               last_tile
);

  localparam int TXW = (TILES_X > 1) ? $clog2(TILES_X) : 1;
  localparam int TYW = (TILES_Y > 1) ? $clog2(TILES_Y) : 1;
  localparam logic [TXW-1:0]     TX_LAST = TXW'(TILES_X - 1);
  localparam logic [TYW-1:0]     TY_LAST = TYW'(TILES_Y - 1);
  localparam logic [COORD_W-1:0] STEP    = COORD_W'(STRIDE);

  logic [TXW-1:0] tx;
  logic [TYW-1:0] ty;

  // Raster walk: step along the row, wrap to the next row at the end.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      tx     <= '0;
      ty     <= '0;
      tile_x <= '0;
      tile_y <= '0;
    end else if (clear) begin
      tx     <= '0;
      ty     <= '0;
      tile_x <= '0;
      tile_y <= '0;
    end else if (advance) begin
      if (tx != TX_LAST) begin
        tx     <= tx + 1'b1;
        tile_x <= tile_x + STEP;
      end else begin
        tx     <= '0;
        tile_x <= '0;
        ty     <= ty + 1'b1;
        tile_y <= tile_y + STEP;
      end
    end
  end

  assign last_tile = (tx == TX_LAST) && (ty == TY_LAST);

endmodule

// File: rtl/integral_cache_fill_scheduler.sv
// Alternates cache fill and detector scan per tile across a frame of overlapping tiles.
// Latency: frame_start->fill_start 1, last word->scan_start 1, scan_done->fill_start 2 cycles.
// Backpressure: upstream/loader pass-through in FILL only; upstream stalled in every other state.
module integral_cache_fill_scheduler
  import pkg_integralImageCache::*;
#(
  parameter int TILE_W  = 24,
  parameter int TILE_H  = 24,
  parameter int TILES_X = 38,
  parameter int TILES_Y = 28,
  parameter int STRIDE  = 8,
  parameter int COORD_W = 10,
  parameter int CNT_W   = 10
) (
  input  logic                           clk,
  input  logic                           resetn,
  integral_cache_fill_scheduler_if.master sif
);

  localparam int TW = tile_words(TILE_W, TILE_H);
  localparam logic [CNT_W-1:0] LAST_WORD = CNT_W'(TW - 1);

  // Parameter sanity: origins plus tile extent must fit the coordinate width,
  // and the word counter must reach the last word of a tile.
  if ((TILES_X - 1) * STRIDE + TILE_W > (2 ** COORD_W)) begin : g_chk_x
    $error("tile_x range exceeds COORD_W");
  end
  if ((TILES_Y - 1) * STRIDE + TILE_H > (2 ** COORD_W)) begin : g_chk_y
    $error("tile_y range exceeds COORD_W");
  end
  if (TW - 1 >= (2 ** CNT_W)) begin : g_chk_cnt
    $error("CNT_W too narrow for one tile of words");
  end

  sched_state_t     state, state_nxt;
  logic [CNT_W-1:0] word_cnt, word_cnt_nxt;
  logic             fill_start_q, fill_start_nxt;
  logic             scan_start_q, scan_start_nxt;
  logic             frame_done_q, frame_done_nxt;
  logic             accept;
  logic             advance;
  logic             clear_origin;
  logic             last_tile;
  logic [COORD_W-1:0] org_x, org_y;

  // Words only flow while filling; elsewhere both directions are forced low.
  assign sif.ld_data_ready  = (state == FILL) && sif.up_data_ready;
  assign sif.up_data_wanted = (state == FILL) && sif.ld_data_wanted;
  assign accept             = (state == FILL) && sif.up_data_ready && sif.ld_data_wanted;

  tile_origin_counter #(
    .TILES_X (TILES_X),
    .TILES_Y (TILES_Y),
    .STRIDE  (STRIDE),
    .COORD_W (COORD_W)
  ) u_origin (
    .clk       (clk),
    .resetn    (resetn),
    .clear     (clear_origin),
    .advance   (advance),
    .tile_x    (org_x),
    .tile_y    (org_y),
    .last_tile (last_tile)
  );

  // State, word count and pulse registers.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state        <= IDLE;
      word_cnt     <= '0;
      fill_start_q <= 1'b0;
      scan_start_q <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      state        <= state_nxt;
      word_cnt     <= word_cnt_nxt;
      fill_start_q <= fill_start_nxt;
      scan_start_q <= scan_start_nxt;
      frame_done_q <= frame_done_nxt;
    end
  end

  // Next-state and pulse decode; pulses are registered so they land in the target state's first cycle.
  always_comb begin
    state_nxt      = state;
    word_cnt_nxt   = word_cnt;
    fill_start_nxt = 1'b0;
    scan_start_nxt = 1'b0;
    frame_done_nxt = 1'b0;
    advance        = 1'b0;
    clear_origin   = 1'b0;
    case (state)
      IDLE: begin
        if (sif.frame_start) begin
          state_nxt      = FILL;
          fill_start_nxt = 1'b1;
          clear_origin   = 1'b1;
          word_cnt_nxt   = '0;
        end
      end
      FILL: begin
        if (accept) begin
          if (word_cnt == LAST_WORD) begin
            word_cnt_nxt   = '0;
            state_nxt      = SCAN;
            scan_start_nxt = 1'b1;
          end else begin
            word_cnt_nxt = word_cnt + 1'b1;
          end
        end
      end
      SCAN: begin
        if (sif.scan_done) state_nxt = ADVANCE;
      end
      ADVANCE: begin
        if (last_tile) begin
          state_nxt      = DONE;
          frame_done_nxt = 1'b1;
        end else begin
          advance        = 1'b1;
          state_nxt      = FILL;
          fill_start_nxt = 1'b1;
        end
      end
      DONE: begin
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  assign sif.fill_start = fill_start_q;
  assign sif.scan_start = scan_start_q;
  assign sif.frame_done = frame_done_q;
  assign sif.busy       = (state != IDLE);
  assign sif.tile_x     = org_x;
  assign sif.tile_y     = org_y;

endmodule

// File: tb/tb_integral_cache_fill_scheduler.sv
// Self-checking bench for integral_cache_fill_scheduler on a 2x2 grid of 2x2-word tiles.
// Latency: n/a.
// Backpressure: exercises loader stalls and upstream gaps.
module tb_integral_cache_fill_scheduler;

  localparam int TILE_W  = 2;
  localparam int TILE_H  = 2;
  localparam int TILES_X = 2;
  localparam int TILES_Y = 2;
  localparam int STRIDE  = 1;
  localparam int COORD_W = 10;
  localparam int CNT_W   = 10;
  localparam int NWORDS  = TILE_W * TILE_H;
  localparam int NTILES  = TILES_X * TILES_Y;

  typedef struct {
    int x;
    int y;
  } org_t;

  typedef struct {
    bit up_rdy;
    bit ld_want;
    bit exp_ld_rdy;
    bit exp_up_want;
    bit exp_accept;
  } vec_t;

  logic clk    = 1'b0;
  logic resetn = 1'b1;
  int   n_pass  = 0;
  int   n_total = 0;
  org_t exp_q[$];
  vec_t idle_vecs[4];
  vec_t fill_vecs[5];

  integral_cache_fill_scheduler_if #(.COORD_W(COORD_W)) sif();

  integral_cache_fill_scheduler #(
    .TILE_W  (TILE_W),
    .TILE_H  (TILE_H),
    .TILES_X (TILES_X),
    .TILES_Y (TILES_Y),
    .STRIDE  (STRIDE),
    .COORD_W (COORD_W),
    .CNT_W   (CNT_W)
  ) dut (
    .clk    (clk),
    .resetn (resetn),
    .sif    (sif)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1);
  end

  task automatic check(input string name, input longint act, input longint exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d required %0d", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_frame();
    org_t o;
    for (int ty = 0; ty < TILES_Y; ty++) begin
      for (int tx = 0; tx < TILES_X; tx++) begin
        o.x = tx * STRIDE;
        o.y = ty * STRIDE;
        exp_q.push_back(o);
      end
    end
  endtask

  task automatic check_origin();
    org_t e;
    if (exp_q.size() == 0) begin
      n_total++;
      $display("FAIL origin_sb: got unexpected scan_start required none");
    end else begin
      e = exp_q.pop_front();
      check("origin_x", sif.tile_x, e.x);
      check("origin_y", sif.tile_y, e.y);
    end
  endtask

  task automatic start_frame();
    push_frame();
    sif.frame_start = 1'b1;
    tick();
    sif.frame_start = 1'b0;
    check("fill_start_lat", sif.fill_start, 1);
    check("busy_fill", sif.busy, 1);
  endtask

  // mode 0: both held high; 1: loader toggles 1,0,..; 2: upstream gaps plus loader toggle
  task automatic fill_tile(input int mode, input int acc0, input bit inject_done);
    int acc;
    int cyc;
    bit got;
    acc = acc0;
    cyc = 0;
    got = 1'b0;
    while (cyc < 40 && !got) begin
      sif.up_data_ready  = (mode == 2) ? ((cyc % 3) != 0) : 1'b1;
      sif.ld_data_wanted = (mode != 0) ? ((cyc % 2) == 0) : 1'b1;
      sif.scan_done      = inject_done && ((cyc % 2) == 1);
      #1;
      check("ld_rdy_pass", sif.ld_data_ready, sif.up_data_ready);
      check("up_want_pass", sif.up_data_wanted, sif.ld_data_wanted);
      if (sif.up_data_ready && sif.ld_data_wanted) acc++;
      tick();
      if (acc == NWORDS) begin
        check("scan_start_after_last", sif.scan_start, 1);
        check_origin();
        got = 1'b1;
      end else begin
        check("scan_start_early", sif.scan_start, 0);
      end
      cyc++;
    end
    sif.scan_done = 1'b0;
    if (!got) begin
      n_total++;
      $display("FAIL fill_timeout: got %0d accepts required %0d", acc, NWORDS);
    end
  endtask

  task automatic scan_tile(input int dly, input bit inject_fs, input bit last);
    sif.up_data_ready  = 1'b1;
    sif.ld_data_wanted = 1'b1;
    #1;
    check("scan_up_want", sif.up_data_wanted, 0);
    check("scan_ld_rdy", sif.ld_data_ready, 0);
    for (int i = 0; i < dly; i++) begin
      sif.frame_start = inject_fs && (i == 0);
      tick();
      sif.frame_start = 1'b0;
      check("scan_no_fill", sif.fill_start, 0);
      check("scan_busy", sif.busy, 1);
      check("scan_ld_hold", sif.ld_data_ready, 0);
    end
    sif.scan_done = 1'b1;
    tick();
    sif.scan_done = 1'b0;
    check("adv_no_fill", sif.fill_start, 0);
    check("adv_no_done", sif.frame_done, 0);
    check("adv_ld_rdy", sif.ld_data_ready, 0);
    tick();
    check("after_adv_fill", sif.fill_start, last ? 0 : 1);
    check("after_adv_done", sif.frame_done, last ? 1 : 0);
    check("after_adv_busy", sif.busy, 1);
  endtask

  task automatic end_of_frame();
    tick();
    check("done_pulse_width", sif.frame_done, 0);
    check("busy_after_done", sif.busy, 0);
    check("hold_x", sif.tile_x, (TILES_X - 1) * STRIDE);
    check("hold_y", sif.tile_y, (TILES_Y - 1) * STRIDE);
    tick();
    check("idle_no_fill", sif.fill_start, 0);
    check("idle_ld_rdy", sif.ld_data_ready, 0);
  endtask

  initial begin
    //                 up  ld  ld_rdy up_want accept
    idle_vecs[0] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    idle_vecs[1] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    idle_vecs[2] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    idle_vecs[3] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    fill_vecs[0] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    fill_vecs[1] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
    fill_vecs[2] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
    fill_vecs[3] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
    fill_vecs[4] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1};

    sif.frame_start    = 1'b0;
    sif.up_data_ready  = 1'b1;
    sif.ld_data_wanted = 1'b0;
    sif.scan_done      = 1'b0;

    // Reset state
    #1 resetn = 1'b0;
    #1;
    check("rst_busy", sif.busy, 0);
    check("rst_fill_start", sif.fill_start, 0);
    check("rst_scan_start", sif.scan_start, 0);
    check("rst_frame_done", sif.frame_done, 0);
    check("rst_up_want", sif.up_data_wanted, 0);
    check("rst_ld_rdy", sif.ld_data_ready, 0);
    check("rst_tile_x", sif.tile_x, 0);
    check("rst_tile_y", sif.tile_y, 0);
    tick();
    tick();
    resetn = 1'b1;
    tick();
    check("rel_no_fill", sif.fill_start, 0);

    // Idle stall table
    foreach (idle_vecs[i]) begin
      sif.up_data_ready  = idle_vecs[i].up_rdy;
      sif.ld_data_wanted = idle_vecs[i].ld_want;
      #1;
      check("idle_ld_rdy_tbl", sif.ld_data_ready, idle_vecs[i].exp_ld_rdy);
      check("idle_up_want_tbl", sif.up_data_wanted, idle_vecs[i].exp_up_want);
      tick();
      check("idle_busy_tbl", sif.busy, 0);
      check("idle_fill_tbl", sif.fill_start, 0);
    end

    // Frame 1: tile 0 opens with the handshake table
    start_frame();
    begin
      int acc;
      acc = 0;
      foreach (fill_vecs[i]) begin
        sif.up_data_ready  = fill_vecs[i].up_rdy;
        sif.ld_data_wanted = fill_vecs[i].ld_want;
        #1;
        check("fill_ld_rdy_tbl", sif.ld_data_ready, fill_vecs[i].exp_ld_rdy);
        check("fill_up_want_tbl", sif.up_data_wanted, fill_vecs[i].exp_up_want);
        if (fill_vecs[i].exp_accept) acc++;
        tick();
        check("fill_tbl_no_scan", sif.scan_start, 0);
      end
      fill_tile(0, acc, 1'b0);
    end
    scan_tile(3, 1'b1, 1'b0);
    fill_tile(1, 0, 1'b1);
    scan_tile(3, 1'b0, 1'b0);
    fill_tile(2, 0, 1'b0);
    scan_tile(3, 1'b0, 1'b0);
    fill_tile(0, 0, 1'b0);
    scan_tile(3, 1'b0, 1'b1);
    end_of_frame();

    // Frame 2: reset two words into the second tile
    start_frame();
    fill_tile(0, 0, 1'b0);
    scan_tile(3, 1'b0, 1'b0);
    sif.up_data_ready  = 1'b1;
    sif.ld_data_wanted = 1'b1;
    tick();
    check("pre_rst_no_scan", sif.scan_start, 0);
    tick();
    check("pre_rst_no_scan", sif.scan_start, 0);
    check("pre_rst_x", sif.tile_x, STRIDE);
    resetn = 1'b0;
    #1;
    check("midrst_busy", sif.busy, 0);
    check("midrst_ld_rdy", sif.ld_data_ready, 0);
    check("midrst_up_want", sif.up_data_wanted, 0);
    check("midrst_tile_x", sif.tile_x, 0);
    check("midrst_tile_y", sif.tile_y, 0);
    exp_q.delete();
    tick();
    resetn = 1'b1;
    tick();
    check("midrel_no_fill", sif.fill_start, 0);
    check("midrel_no_scan", sif.scan_start, 0);
    check("midrel_no_done", sif.frame_done, 0);
    check("midrel_busy", sif.busy, 0);

    // Frame 3: fresh frame after reset needs full tiles again
    start_frame();
    for (int t = 0; t < NTILES; t++) begin
      fill_tile(0, 0, 1'b0);
      scan_tile(3, 1'b0, t == NTILES - 1);
    end
    end_of_frame();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
